// File: rtl/a_to_b_feeder_pkg.sv
// Shared types and defaults for the a_to_b_feeder slice.
package a_to_b_feeder_pkg;

  localparam int A2B_FROM_W       = 8;
  localparam int A2B_TO_W         = 8;
  localparam int A2B_FIFO_DEPTH   = 4;
  localparam int A2B_DWELL_CYCLES = 2;

  typedef enum logic [1:0] {
    A2B_IDLE  = 2'd0,
    A2B_DRIVE = 2'd1,
    A2B_RESP  = 2'd2
  } a2b_state_e;

  // Dwell counter width; a single bit is kept even when DWELL_CYCLES == 1.
  function automatic int a2b_cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/a_to_b_feeder_fifo.sv
// Small synchronous FIFO; head reads straight out of the storage flops.
module a_to_b_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty; wrap is natural overflow.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/a_to_b_feeder.sv
// Feeds module_b one word at a time, holds it for a fixed dwell, then
// returns module_b's reply on a valid/ready response stream.
module a_to_b_feeder
  import a_to_b_feeder_pkg::*;
#(
  parameter int DATA_FROM_A_BITWIDTH = A2B_FROM_W,
  parameter int DATA_TO_A_BITWIDTH   = A2B_TO_W,
  parameter int FIFO_DEPTH           = A2B_FIFO_DEPTH,
  parameter int DWELL_CYCLES         = A2B_DWELL_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_FROM_A_BITWIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_FROM_A_BITWIDTH-1:0] data_from_a,
  input  logic [DATA_TO_A_BITWIDTH-1:0]   data_to_a,
  output logic [DATA_TO_A_BITWIDTH-1:0]   rsp_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            busy
);

  localparam int              CNT_W    = a2b_cnt_w(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL_CYCLES - 1);

  a2b_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DATA_FROM_A_BITWIDTH-1:0] drv_q, drv_d;
  logic [DATA_TO_A_BITWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                            rsp_valid_q, rsp_valid_d;

  logic                            push, pop, full, empty;
  logic [DATA_FROM_A_BITWIDTH-1:0] head;

  // in_ready comes only from registered pointers, so a pop never re-opens
  // it within the same cycle.
  assign in_ready = !full;
  assign push     = in_valid && !full;

  a_to_b_fifo #(
    .WIDTH (DATA_FROM_A_BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Sequencer next state: load word, dwell, capture reply, hand it off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drv_d       = drv_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;
    case (state_q)
      A2B_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          drv_d   = head;
          cnt_d   = CNT_INIT;
          state_d = A2B_DRIVE;
        end
      end
      A2B_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d  = data_to_a;
          rsp_valid_d = 1'b1;
          state_d     = A2B_RESP;
        end
      end
      A2B_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Back-to-back: next word loads on the same edge the reply leaves.
          if (!empty) begin
            pop     = 1'b1;
            drv_d   = head;
            cnt_d   = CNT_INIT;
            state_d = A2B_DRIVE;
          end else begin
            state_d = A2B_IDLE;
          end
        end
      end
      default: state_d = A2B_IDLE;
    endcase
  end

  // Sequencer and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= A2B_IDLE;
      cnt_q       <= '0;
      drv_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drv_q       <= drv_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign data_from_a = drv_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign busy        = (state_q != A2B_IDLE) || !empty;

endmodule

// File: tb/tb_a_to_b_feeder.sv
// Bench for a_to_b_feeder: three instances (dwell 2, 1, 5) sharing clk/rst,
// each with a module_b stand-in that replies data_from_a ^ b_mask.
module tb_a_to_b_feeder;
  import a_to_b_feeder_pkg::*;

  localparam int FW = A2B_FROM_W;
  localparam int TW = A2B_TO_W;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_data     [NI];
  logic          in_valid    [NI];
  logic          in_ready    [NI];
  logic [FW-1:0] data_from_a [NI];
  logic [TW-1:0] data_to_a   [NI];
  logic [TW-1:0] rsp_data    [NI];
  logic          rsp_valid   [NI];
  logic          rsp_ready   [NI];
  logic          busy        [NI];
  logic [TW-1:0] b_mask      [NI];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_to_a[0] = TW'(data_from_a[0]) ^ b_mask[0];
  assign data_to_a[1] = TW'(data_from_a[1]) ^ b_mask[1];
  assign data_to_a[2] = TW'(data_from_a[2]) ^ b_mask[2];

  a_to_b_feeder #(.DATA_FROM_A_BITWIDTH(FW), .DATA_TO_A_BITWIDTH(TW),
                  .FIFO_DEPTH(4), .DWELL_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .data_from_a(data_from_a[0]), .data_to_a(data_to_a[0]),
    .rsp_data(rsp_data[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .busy(busy[0]));

  a_to_b_feeder #(.DATA_FROM_A_BITWIDTH(FW), .DATA_TO_A_BITWIDTH(TW),
                  .FIFO_DEPTH(4), .DWELL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .data_from_a(data_from_a[1]), .data_to_a(data_to_a[1]),
    .rsp_data(rsp_data[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .busy(busy[1]));

  a_to_b_feeder #(.DATA_FROM_A_BITWIDTH(FW), .DATA_TO_A_BITWIDTH(TW),
                  .FIFO_DEPTH(4), .DWELL_CYCLES(5)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .data_from_a(data_from_a[2]), .data_to_a(data_to_a[2]),
    .rsp_data(rsp_data[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .busy(busy[2]));

  function automatic int dwell_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; rsp_ready[k] = 1'b0; b_mask[k] = '1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      vectors++; if (data_from_a[k] !== '0) begin miscompares++; $display("FAIL reset_data_from_a[%0d]: got %h want 0", k, data_from_a[k]); end
      vectors++; if (rsp_data[k] !== '0) begin miscompares++; $display("FAIL reset_rsp_data[%0d]: got %h want 0", k, rsp_data[k]); end
      vectors++; if (rsp_valid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", k, rsp_valid[k]); end
      vectors++; if (busy[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
    end
  endtask

  task automatic test_single();
    b_mask[0] = 8'hFF; rsp_ready[0] = 1'b1;
    @(negedge clk);
    in_data[0] = 8'h3C; in_valid[0] = 1'b1;
    // accept edge E0 is the next posedge; t counts negedges after E0+t
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      if (t >= 1) begin
        vectors++; if (data_from_a[0] !== 8'h3C) begin miscompares++; $display("FAIL single_drive t=%0d: got %h want 3c", t, data_from_a[0]); end
      end
      vectors++; if (rsp_valid[0] !== (t == 3)) begin miscompares++; $display("FAIL single_rsp_valid t=%0d: got %b want %b", t, rsp_valid[0], (t == 3)); end
      if (t == 3) begin
        vectors++; if (rsp_data[0] !== 8'hC3) begin miscompares++; $display("FAIL single_rsp_data: got %h want c3", rsp_data[0]); end
      end
      if (t == 4) begin
        vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b want 0", busy[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] w;
    int c0 = 0, nresp = 0;
    b_mask[0] = 8'hFF; rsp_ready[0] = 1'b1;
    for (int i = 0; i < 40 && nresp < 4; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; $display("FAIL b2b_extra_rsp: got %h want none", rsp_data[0]);
        end else begin
          w = exp_q.pop_front();
          vectors++; if (rsp_data[0] !== (w ^ 8'hFF)) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", nresp, rsp_data[0], w ^ 8'hFF); end
          vectors++; if (cyc != c0 + 4 + 3 * nresp) begin miscompares++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", nresp, cyc, c0 + 4 + 3 * nresp); end
        end
        nresp++;
      end
      if (i < 4) begin
        vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready[0]); end
        if (i == 0) c0 = cyc;
        in_data[0] = FW'(i + 1); in_valid[0] = 1'b1;
        exp_q.push_back(FW'(i + 1));
      end else begin
        in_valid[0] = 1'b0;
      end
    end
    vectors++; if (nresp != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", nresp); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_stall();
    logic [FW-1:0] w[6];
    int acc = 0, nr = 0;
    for (int i = 0; i < 6; i++) w[i] = FW'($urandom);
    b_mask[0] = 8'hFF; rsp_ready[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        vectors++; if (rsp_data[0] !== (w[0] ^ 8'hFF)) begin miscompares++; $display("FAIL stall_hold_data: got %h want %h", rsp_data[0], w[0] ^ 8'hFF); end
      end
      if (acc < 6) begin
        in_data[0] = w[acc]; in_valid[0] = 1'b1;
        if (in_ready[0]) acc++;
      end
    end
    vectors++; if (acc != 5) begin miscompares++; $display("FAIL stall_accepted: got %0d want 5", acc); end
    vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", in_ready[0]); end
    vectors++; if (rsp_valid[0] !== 1'b1) begin miscompares++; $display("FAIL stall_rsp_valid: got %b want 1", rsp_valid[0]); end
    // release: first reply leaves at the next edge, popping one word
    rsp_ready[0] = 1'b1;
    nr = 1;
    @(negedge clk);
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL stall_reopen: got %b want 1", in_ready[0]); end
    for (int i = 0; i < 60 && nr < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (acc >= 6) in_valid[0] = 1'b0;
      else if (in_ready[0]) acc = 6;
      if (rsp_valid[0]) begin
        vectors++; if (rsp_data[0] !== (w[nr] ^ 8'hFF)) begin miscompares++; $display("FAIL stall_drain[%0d]: got %h want %h", nr, rsp_data[0], w[nr] ^ 8'hFF); end
        nr++;
      end
    end
    in_valid[0] = 1'b0;
    vectors++; if (nr != 6) begin miscompares++; $display("FAIL stall_drain_count: got %0d want 6", nr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_dwell(input int k);
    int d;
    logic [FW-1:0] w;
    logic [TW-1:0] last;
    d = dwell_of(k);
    w = FW'($urandom);
    last = b_mask[k];
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    in_data[k] = w; in_valid[k] = 1'b1;
    for (int t = 1; t <= d + 1; t++) begin
      @(negedge clk);
      in_valid[k] = 1'b0;
      vectors++; if (rsp_valid[k] !== 1'b0) begin miscompares++; $display("FAIL dwell%0d_early_valid t=%0d: got %b want 0", d, t, rsp_valid[k]); end
      if (t >= 2) begin
        vectors++; if (data_from_a[k] !== w) begin miscompares++; $display("FAIL dwell%0d_hold t=%0d: got %h want %h", d, t, data_from_a[k], w); end
      end
      // module_b reply changes every cycle of the dwell; only the last counts
      b_mask[k] = TW'($urandom);
      last = b_mask[k];
    end
    @(negedge clk);
    b_mask[k] = ~last;
    vectors++; if (rsp_valid[k] !== 1'b1) begin miscompares++; $display("FAIL dwell%0d_capture_edge: got %b want 1", d, rsp_valid[k]); end
    vectors++; if (rsp_data[k] !== (TW'(w) ^ last)) begin miscompares++; $display("FAIL dwell%0d_capture_data: got %h want %h", d, rsp_data[k], TW'(w) ^ last); end
    repeat (2) @(negedge clk);
    vectors++; if (busy[k] !== 1'b0) begin miscompares++; $display("FAIL dwell%0d_idle: got %b want 0", d, busy[k]); end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] w0;
    b_mask[0] = 8'hFF; rsp_ready[0] = 1'b1;
    w0 = FW'($urandom) | 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data[0] = (i == 0) ? w0 : FW'($urandom); in_valid[0] = 1'b1;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    vectors++; if (data_from_a[0] !== w0) begin miscompares++; $display("FAIL midrst_pre_drive: got %h want %h", data_from_a[0], w0); end
    vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b want 1", busy[0]); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (data_from_a[0] !== '0) begin miscompares++; $display("FAIL midrst_data_from_a: got %h want 0", data_from_a[0]); end
    vectors++; if (rsp_data[0] !== '0) begin miscompares++; $display("FAIL midrst_rsp_data: got %h want 0", rsp_data[0]); end
    vectors++; if (rsp_valid[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid[0]); end
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready[0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_stale i=%0d: got valid=%b busy=%b want 0/0", i, rsp_valid[0], busy[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] w;
    logic [TW-1:0] m;
    int pushed = 0, got = 0;
    logic acc_prev = 1'b0;
    m = TW'($urandom);
    b_mask[0] = m;
    in_valid[0] = 1'b0;
    for (int i = 0; i < 3000 && got < 37; i++) begin
      @(negedge clk);
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; $display("FAIL wrap_extra_rsp: got %h want none", rsp_data[0]);
        end else begin
          w = exp_q.pop_front();
          vectors++; if (rsp_data[0] !== (TW'(w) ^ m)) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", got, rsp_data[0], TW'(w) ^ m); end
        end
        got++;
      end
      if (acc_prev) in_valid[0] = 1'b0;
      if (!in_valid[0] && pushed < 37 && $urandom_range(0, 2) != 0) begin
        in_data[0] = FW'($urandom); in_valid[0] = 1'b1;
      end
      acc_prev = in_valid[0] && in_ready[0];
      if (acc_prev) begin
        exp_q.push_back(in_data[0]);
        pushed++;
      end
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    vectors++; if (got != 37 || pushed != 37) begin miscompares++; $display("FAIL wrap_count: got %0d rsp / %0d pushed want 37/37", got, pushed); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_dwell(0);
    test_dwell(1);
    test_dwell(2);
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
